// File: rtl/noc_credit_tx_if.sv
// noc_credit_tx_if: producer handshake and node-side valid/yummy signals of the credit transmitter
interface noc_credit_tx_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] data_in;
  logic valid_in;
  logic ready_out;
  logic [DATA_WIDTH-1:0] dataOut;
  logic validOut;
  logic yummyIn;
  modport master (
    output data_in, valid_in, yummyIn,
    input ready_out, dataOut, validOut
  );
  modport slave (
    input data_in, valid_in, yummyIn,
    output ready_out, dataOut, validOut
  );
endinterface

// File: rtl/noc_credit_tx.sv
// noc_credit_tx: buffers producer flits and forwards them to a node port while downstream credits last
module noc_credit_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int FW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input logic clk,
  input logic rst_n,
  noc_credit_tx_if.slave bus,
  output logic [CW-1:0] credit_count,
  output logic [FW-1:0] fifo_count,
  output logic err_credit_ovf
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic push, send, ovf;
  assign bus.ready_out = fifo_count != FW'(FIFO_DEPTH);
  assign push = bus.valid_in & bus.ready_out;
  assign send = (fifo_count != '0) & (credit_count != '0);
  // a yummy with no matching send at full credit cannot be absorbed
  assign ovf = bus.yummyIn & ~send & (credit_count == CW'(CREDITS));
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= bus.data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      fifo_count <= '0;
      credit_count <= CW'(CREDITS);
      bus.validOut <= 1'b0;
      bus.dataOut <= '0;
      err_credit_ovf <= 1'b0;
    end else begin
      wrPtr <= push ? wrPtr + PW'(1) : wrPtr;
      rdPtr <= send ? rdPtr + PW'(1) : rdPtr;
      fifo_count <= fifo_count + FW'(push) - FW'(send);
      credit_count <= ovf ? credit_count : credit_count - CW'(send) + CW'(bus.yummyIn);
      bus.validOut <= send;
      bus.dataOut <= send ? mem[rdPtr] : bus.dataOut;
      err_credit_ovf <= err_credit_ovf | ovf;
    end
endmodule

// File: doc/noc_credit_tx.md
Name: noc_credit_tx

Overview:
Credit-based flit transmitter that drives one input port of a dynamic network node: dataIn_x/validIn_x on the node side, with yummyOut_x returned as credits. It accepts flits from a local producer through a valid/ready handshake into a small FIFO. It forwards each flit to the node only while downstream buffer credits remain, and restores one credit per yummy pulse received. It is the sending end of the valid/yummy protocol whose node-side receiver is exercised by the dynamic node playback bench.

Parameters:
DATA_WIDTH, 64, flit width in bits.
FIFO_DEPTH, 4, local buffer entries; power of 2, minimum 2.
CREDITS, 4, downstream node input-buffer depth; the initial and maximum credit count.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
data_in  input  DATA_WIDTH  flit from the local producer.
valid_in  input  1  producer flit valid.
ready_out  output  1  transmitter can accept a flit this cycle.
dataOut  output  DATA_WIDTH  flit to the node dataIn port.
validOut  output  1  flit valid to the node validIn port.
yummyIn  input  1  one-cycle credit-return pulse from the node yummyOut port.
credit_count  output  clog2(CREDITS+1)  current available credits.
fifo_count  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
err_credit_ovf  output  1  sticky flag: a yummy arrived while credits were already at CREDITS.

Behaviour:
- Reset (rst_n low, async): FIFO empty, credit_count=CREDITS, validOut=0, dataOut=0, err_credit_ovf=0, ready_out=1 once reset is released.
- Enqueue: at a rising edge where valid_in & ready_out, data_in is written at the tail. ready_out = (fifo_count != FIFO_DEPTH). It is combinational from state only; there is no same-cycle pop bypass.
- Send decision: every cycle, send = (fifo_count != 0) & (credit_count != 0). At the edge where send=1:
  - the head is popped;
  - dataOut <= head, validOut <= 1;
  - credit_count decrements.
  At an edge where send=0: validOut <= 0, and dataOut holds its last value.
- Latency: a flit accepted at edge E appears on validOut/dataOut after edge E+1, at the earliest. Back-to-back sends are possible every cycle while credits and FIFO entries last, giving full throughput.
- Outputs are registered; validOut is never combinationally dependent on yummyIn or valid_in.
- Credit update per edge: credit_next = credit_count - send + yummyIn. A simultaneous send and yummy leaves the count unchanged.
- A yummy with credit_count==CREDITS and no send: the count saturates at CREDITS, and err_credit_ovf is set and held until reset.
- A yummy arriving while credit_count==0 restores one credit. A send may occur at the following edge, not at the same edge.
- Simultaneous enqueue and pop: occupancy is unchanged. At FIFO_DEPTH full, ready_out=0 even if a pop occurs that same edge.
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap naturally; occupancy is tracked by a separate counter.
- Flit order is strict FIFO, and no flit is ever dropped or duplicated.
- Reset asserted mid-transfer discards all buffered flits and restores full credits immediately; validOut drops asynchronously.

Test Plan:
- Reset then idle: after rst_n rises, credit_count=4, fifo_count=0, ready_out=1, validOut=0 for 10 cycles with no yummy.
- Single flit: push 0xDEADBEEF_00000001 at edge 5. Required: validOut=1 with that data after edge 6 for exactly one cycle, and credit_count=3 afterwards.
- Credit exhaustion: push 6 flits 0x1..0x6 back-to-back with no yummy. Required: exactly 4 flits (0x1..0x4) sent on consecutive cycles, credit_count=0, fifo_count=2, validOut low thereafter. One yummy then releases 0x5 one edge later, and a second yummy releases 0x6.
- FIFO full: with credits held at 0, push until ready_out=0 with fifo_count=4. Required: a further valid_in is not accepted. A yummy pulse causes one pop, and ready_out returns to 1 on the next cycle.
- Simultaneous send and yummy: with credit_count=2, a flit queued, and yummyIn asserted on the send edge, credit_count stays 2.
- Overflow and mid-operation reset: a yummy at credit_count=4 sets err_credit_ovf=1 and the count stays 4. Then, with 3 flits queued and 0 credits, asserting rst_n low clears the FIFO, sets credits to 4, and clears err_credit_ovf, with validOut=0 immediately.
